// File: rtl/pilot_pkg.sv
// Shared types, default widths and config validation for the pilot-insertion scheduler.
package pilot_pkg;

  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned DEF_LEN_W      = 13;
  localparam int unsigned DEF_GAP_W      = 8;
  localparam int unsigned DEF_NUM_PILOTS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_GAP
  } state_e;

  function automatic logic cfg_ok(input int unsigned len, input int unsigned intv);
    return (len >= 2) && (intv >= 2) && (intv <= len);
  endfunction

endpackage

// File: rtl/pilot_table.sv
// Pilot value register file: one synchronous write port, one asynchronous read port.
module pilot_table #(
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned NUM_PILOTS = 4,
  localparam int unsigned PIDX_W     = $clog2(NUM_PILOTS)
) (
  input  logic              clk,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [PIDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [PIDX_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [NUM_PILOTS];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees pre-edge contents, so a same-cycle write returns the old value.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pilot_scheduler.sv
// Frame scheduler: emits fixed-length frames with table-driven pilots every N positions and an optional idle gap.
module pilot_scheduler
  import pilot_pkg::*;
#(
  parameter  int unsigned DATA_W     = DEF_DATA_W,
  parameter  int unsigned LEN_W      = DEF_LEN_W,
  parameter  int unsigned NUM_PILOTS = DEF_NUM_PILOTS,
  parameter  int unsigned GAP_W      = DEF_GAP_W,
  localparam int unsigned PIDX_W     = $clog2(NUM_PILOTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [LEN_W-1:0]  cfg_frame_length,
  input  logic [LEN_W-1:0]  cfg_pilot_interval,
  input  logic [GAP_W-1:0]  cfg_gap_length,
  input  logic              cfg_pilot_we,
  input  logic [PIDX_W-1:0] cfg_pilot_addr,
  input  logic [DATA_W-1:0] cfg_pilot_data,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_pilot,
  output logic              m_sof,
  output logic              m_eof,
  output logic              cfg_error,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d, int_q, int_d;
  logic [LEN_W-1:0]  pos_q, pos_d, cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d, gcnt_q, gcnt_d;
  logic [PIDX_W-1:0] pidx_q, pidx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] mdata_q, mdata_d;
  logic              mvalid_q, mvalid_d, mpilot_q, mpilot_d;
  logic              msof_q, msof_d, meof_q, meof_d;

  logic [DATA_W-1:0] pilot_word;
  logic              cfg_valid, out_free, pilot_slot, fire, last, decide;

  pilot_table #(
    .DATA_W    (DATA_W),
    .NUM_PILOTS(NUM_PILOTS)
  ) u_table (
    .clk    (clk),
    .rst_ni (rst),
    .we_i   (cfg_pilot_we),
    .waddr_i(cfg_pilot_addr),
    .wdata_i(cfg_pilot_data),
    .raddr_i(pidx_q),
    .rdata_o(pilot_word)
  );

  assign cfg_valid  = cfg_ok(32'(cfg_frame_length), 32'(cfg_pilot_interval));
  assign out_free   = !mvalid_q || m_ready;
  // cnt_q counts positions until the next pilot; zero marks a pilot slot.
  assign pilot_slot = (cnt_q == '0);
  assign fire       = (state_q == ST_RUN) && out_free && (pilot_slot || s_valid);
  assign last       = (pos_q == len_q - LEN_W'(1));
  assign s_ready    = (state_q == ST_RUN) && !pilot_slot && out_free;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    int_d    = int_q;
    gap_d    = gap_q;
    pos_d    = pos_q;
    cnt_d    = cnt_q;
    gcnt_d   = gcnt_q;
    pidx_d   = pidx_q;
    err_d    = err_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    mpilot_d = mpilot_q;
    msof_d   = msof_q;
    meof_d   = meof_q;
    decide   = 1'b0;

    if (out_free) mvalid_d = 1'b0;
    if (fire) begin
      mvalid_d = 1'b1;
      mdata_d  = pilot_slot ? pilot_word : s_data;
      mpilot_d = pilot_slot;
      msof_d   = (pos_q == '0);
      meof_d   = last;
    end

    case (state_q)
      ST_IDLE: decide = enable;
      ST_RUN: begin
        if (fire) begin
          pos_d = pos_q + LEN_W'(1);
          if (pilot_slot) begin
            cnt_d  = int_q - LEN_W'(1);
            pidx_d = pidx_q + PIDX_W'(1);
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
          if (last) begin
            if (gap_q != '0) begin
              state_d = ST_GAP;
              gcnt_d  = gap_q;
            end else begin
              decide = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        // Gap cycles only count once the eof word has left the output register.
        if (out_free) begin
          if (gcnt_q == GAP_W'(1)) decide = 1'b1;
          else                     gcnt_d = gcnt_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (decide) begin
      if (enable && cfg_valid) begin
        state_d = ST_RUN;
        len_d   = cfg_frame_length;
        int_d   = cfg_pilot_interval;
        gap_d   = cfg_gap_length;
        pos_d   = '0;
        cnt_d   = '0;
        pidx_d  = '0;
        err_d   = 1'b0;
      end else begin
        state_d = ST_IDLE;
        if (!cfg_valid) err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      len_q    <= '0;
      int_q    <= '0;
      gap_q    <= '0;
      pos_q    <= '0;
      cnt_q    <= '0;
      gcnt_q   <= '0;
      pidx_q   <= '0;
      err_q    <= 1'b0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      mpilot_q <= 1'b0;
      msof_q   <= 1'b0;
      meof_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      int_q    <= int_d;
      gap_q    <= gap_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      gcnt_q   <= gcnt_d;
      pidx_q   <= pidx_d;
      err_q    <= err_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      mpilot_q <= mpilot_d;
      msof_q   <= msof_d;
      meof_q   <= meof_d;
    end
  end

  assign m_data    = mdata_q;
  assign m_valid   = mvalid_q;
  assign m_pilot   = mpilot_q;
  assign m_sof     = msof_q;
  assign m_eof     = meof_q;
  assign cfg_error = err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pilot_scheduler.sv
// Directed bench for pilot_scheduler: frame content, gap, backpressure, invalid config, mid-frame changes, reset.
module tb_pilot_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [12:0] cfg_frame_length, cfg_pilot_interval;
  logic [7:0]  cfg_gap_length;
  logic        cfg_pilot_we;
  logic [1:0]  cfg_pilot_addr;
  logic [31:0] cfg_pilot_data;
  logic [31:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] m_data;
  logic        m_valid, m_ready, m_pilot, m_sof, m_eof, cfg_error, busy;

  pilot_scheduler #(
    .DATA_W    (32),
    .LEN_W     (13),
    .NUM_PILOTS(4),
    .GAP_W     (8)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .enable            (enable),
    .cfg_frame_length  (cfg_frame_length),
    .cfg_pilot_interval(cfg_pilot_interval),
    .cfg_gap_length    (cfg_gap_length),
    .cfg_pilot_we      (cfg_pilot_we),
    .cfg_pilot_addr    (cfg_pilot_addr),
    .cfg_pilot_data    (cfg_pilot_data),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_pilot           (m_pilot),
    .m_sof             (m_sof),
    .m_eof             (m_eof),
    .cfg_error         (cfg_error),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] d;
    logic        p;
    logic        s;
    logic        e;
  } word_t;

  word_t       q[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc;
  logic [31:0] src;
  logic        hold_pending;
  logic [35:0] held;

  logic [31:0] F1 [8] = '{32'hA0, 32'd1, 32'd2, 32'd3, 32'hA1, 32'd4, 32'd5, 32'd6};
  logic [31:0] F2 [8] = '{32'hA0, 32'd7, 32'd8, 32'd9, 32'hA1, 32'd10, 32'd11, 32'd12};
  logic [31:0] F3 [8] = '{32'hA0, 32'd7, 32'hA1, 32'd8, 32'hA2, 32'd9, 32'hA3, 32'd10};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, sample at posedge+3, advance to posedge+1.
  task automatic tick(input logic rdy, input logic vld);
    logic in_acc;
    m_ready = rdy;
    s_valid = vld;
    s_data  = src;
    #2;
    if (hold_pending)
      chk("hold_stable", 64'({m_valid, m_data, m_pilot, m_sof, m_eof}), 64'(held));
    if (m_valid && m_ready) q.push_back('{cyc, m_data, m_pilot, m_sof, m_eof});
    hold_pending = m_valid && !m_ready;
    held         = {m_valid, m_data, m_pilot, m_sof, m_eof};
    in_acc       = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (in_acc) src++;
    cyc++;
  endtask

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      cfg_pilot_we   = 1'b1;
      cfg_pilot_addr = 2'(i);
      cfg_pilot_data = 32'hA0 + 32'(i);
      @(posedge clk);
      #1;
    end
    cfg_pilot_we = 1'b0;
  endtask

  task automatic setup(input int l, input int i, input int g);
    enable = 1'b0;
    rst    = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    load_table();
    cfg_frame_length   = 13'(l);
    cfg_pilot_interval = 13'(i);
    cfg_gap_length     = 8'(g);
    m_ready      = 1'b1;
    s_valid      = 1'b0;
    q.delete();
    src          = 32'd1;
    cyc          = 0;
    hold_pending = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int base, input logic [31:0] ed [8],
                         input logic [7:0] pmask);
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("%s_present%0d", tag, j), 64'(q.size() > base + j), 64'(1));
      if (q.size() > base + j)
        chk($sformatf("%s_word%0d", tag, j),
            64'({q[base+j].d, q[base+j].p, q[base+j].s, q[base+j].e}),
            64'({ed[j], pmask[j], j == 0, j == 7}));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; enable = 1'b0;
    cfg_frame_length = 13'd8; cfg_pilot_interval = 13'd4; cfg_gap_length = 8'd0;
    cfg_pilot_we = 1'b0; cfg_pilot_addr = '0; cfg_pilot_data = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b1;
    src = 32'd1; cyc = 0; hold_pending = 1'b0; held = '0;
    #1;
    chk("reset_ctrl", 64'({s_ready, m_valid, m_pilot, m_sof, m_eof, cfg_error, busy}), 64'(0));
    chk("reset_data", 64'(m_data), 64'(0));
    @(posedge clk);
    #1;

    // Basic frames, back-to-back
    setup(8, 4, 0);
    enable = 1'b1;
    repeat (24) tick(1'b1, 1'b1);
    chk_seq("t1f1", 0, F1, 8'b0001_0001);
    chk_seq("t1f2", 8, F2, 8'b0001_0001);
    if (q.size() > 8) chk("t1_b2b_spacing", 64'(q[8].cyc - q[7].cyc), 64'(1));

    // Idle gap of 3
    setup(8, 4, 3);
    enable = 1'b1;
    repeat (30) tick(1'b1, 1'b1);
    chk_seq("t2f1", 0, F1, 8'b0001_0001);
    chk_seq("t2f2", 8, F2, 8'b0001_0001);
    if (q.size() > 8) chk("t2_gap_cycles", 64'(q[8].cyc - q[7].cyc - 1), 64'(3));

    // Backpressure 1,0,0,1 with random input valid
    setup(8, 4, 0);
    enable = 1'b1;
    for (int c = 0; c < 120; c++)
      tick((c % 4 == 0) || (c % 4 == 3), 1'($urandom_range(0, 1)));
    chk_seq("t3f1", 0, F1, 8'b0001_0001);
    chk_seq("t3f2", 8, F2, 8'b0001_0001);

    // Invalid configurations, then fixed
    setup(8, 1, 0);
    enable = 1'b1;
    repeat (5) tick(1'b1, 1'b1);
    chk("t4_i1_err", 64'(cfg_error), 64'(1));
    chk("t4_i1_busy", 64'(busy), 64'(0));
    chk("t4_i1_words", 64'(q.size()), 64'(0));
    cfg_pilot_interval = 13'd9;
    repeat (3) tick(1'b1, 1'b1);
    chk("t4_i9_err", 64'(cfg_error), 64'(1));
    chk("t4_i9_busy", 64'(busy), 64'(0));
    chk("t4_i9_words", 64'(q.size()), 64'(0));
    cfg_pilot_interval = 13'd4;
    tick(1'b1, 1'b1);
    chk("t4_fix_state", 64'({busy, cfg_error}), 64'(2'b10));
    tick(1'b1, 1'b1);
    chk("t4_fix_first", 64'({m_valid, m_sof, m_pilot, m_data}), 64'({3'b111, 32'hA0}));

    // Config change and enable drop mid-frame
    setup(8, 4, 0);
    enable = 1'b1;
    for (int c = 0; c < 40 && !(q.size() > 0 && q[q.size()-1].d == 32'd3); c++)
      tick(1'b1, 1'b1);
    chk("t5_reached_pos3", 64'(q.size()), 64'(4));
    cfg_pilot_interval = 13'd2;
    enable = 1'b0;
    repeat (20) tick(1'b1, 1'b1);
    chk("t5_one_frame", 64'(q.size()), 64'(8));
    chk_seq("t5f1", 0, F1, 8'b0001_0001);
    chk("t5_idle", 64'({busy, cfg_error, m_valid}), 64'(0));
    enable = 1'b1;
    repeat (12) tick(1'b1, 1'b1);
    chk_seq("t5f2", 8, F3, 8'b0101_0101);

    // Asynchronous reset mid-frame
    setup(8, 4, 0);
    enable = 1'b1;
    for (int c = 0; c < 40 && !(m_valid && m_data == 32'd4); c++)
      tick(1'b1, 1'b1);
    chk("t6_at_pos5", 64'({m_valid, m_data}), 64'({1'b1, 32'd4}));
    rst = 1'b0;
    #1;
    chk("t6_rst_ctrl", 64'({s_ready, m_valid, m_pilot, m_sof, m_eof, cfg_error, busy}), 64'(0));
    chk("t6_rst_data", 64'(m_data), 64'(0));
    enable = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    load_table();
    q.delete();
    src = 32'd1;
    cyc = 0;
    hold_pending = 1'b0;
    enable = 1'b1;
    repeat (12) tick(1'b1, 1'b1);
    chk_seq("t6f1", 0, F1, 8'b0001_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
